// File: rtl/gpio_msg_link_pkg.sv
// Shared types and sizing helpers for the GPIO message link.
package gpio_msg_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        S_SETUP,
        S_WAIT_ACK,
        S_WAIT_NACK,
        R_WAIT_REQ,
        R_WAIT_NREQ
    } link_state_e;

    localparam int DEF_MSG_BITS    = 128;
    localparam int DEF_LANES       = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT     = 1023;

    // Number of beats needed to move one message.
    function automatic int calc_beats(input int msg_bits, input int lanes);
        return msg_bits / lanes;
    endfunction

    // Width of an up-counter that must hold values 0..max_val (beat counter, timer).
    function automatic int calc_cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/gpio_msg_link_sync_chain.sv
// Multi-flop synchroniser for one asynchronous strobe, cleared by reset.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/gpio_msg_link.sv
// Board-to-board message link: one message moved LSB-first over LANES pins, four-phase req/ack per beat.
// tx_valid/tx_ready: a message is accepted on a cycle where both are high; tx_data must be valid on that cycle.
module gpio_msg_link
    import gpio_msg_link_pkg::*;
#(
    parameter int MSG_BITS    = DEF_MSG_BITS,
    parameter int LANES       = DEF_LANES,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                role,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [MSG_BITS-1:0] tx_data,
    output logic                rx_valid,
    output logic [MSG_BITS-1:0] rx_data,
    output logic [LANES-1:0]    link_data_out,
    output logic                link_data_oe,
    input  logic [LANES-1:0]    link_data_in,
    output logic                link_req_out,
    input  logic                link_req_in,
    output logic                link_ack_out,
    input  logic                link_ack_in,
    output logic                busy,
    output logic                timeout_err
);

    localparam int BEATS   = calc_beats(MSG_BITS, LANES);
    localparam int BEAT_W  = calc_cnt_w(BEATS - 1);
    localparam int TIMER_W = calc_cnt_w(TIMEOUT);
    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    link_state_e         r_state;
    link_state_e         w_next_state;
    logic [BEAT_W-1:0]   r_beat;
    logic [TIMER_W-1:0]  r_timer;
    logic [MSG_BITS-1:0] r_shift;
    logic [MSG_BITS-1:0] r_asm;
    logic [MSG_BITS-1:0] r_rx_data;
    logic                r_rx_valid;
    logic                r_timeout_err;
    logic                r_alive;

    logic w_req_s, w_ack_s;
    logic w_tx_ready, w_tx_phase;
    logic w_timer_en, w_expire;
    logic w_start, w_tx_next, w_capture, w_rx_next, w_rx_done;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync_req (
        .i_clk   (clock),
        .i_rst_n (resetn),
        .i_d     (link_req_in),
        .o_q     (w_req_s)
    );

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync_ack (
        .i_clk   (clock),
        .i_rst_n (resetn),
        .i_d     (link_ack_in),
        .o_q     (w_ack_s)
    );

    // r_alive keeps tx_ready low while reset is held and for the release cycle.
    assign w_tx_ready = (r_state == IDLE) && !role && r_alive;
    assign w_tx_phase = (r_state == S_SETUP) || (r_state == S_WAIT_ACK) || (r_state == S_WAIT_NACK);

    always_comb begin
        w_next_state = r_state;
        w_timer_en   = 1'b0;
        w_expire     = 1'b0;
        w_start      = 1'b0;
        w_tx_next    = 1'b0;
        w_capture    = 1'b0;
        w_rx_next    = 1'b0;
        w_rx_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (role) begin
                    w_next_state = R_WAIT_REQ;
                end else if (tx_valid && w_tx_ready) begin
                    w_start      = 1'b1;
                    w_next_state = S_SETUP;
                end
            end
            S_SETUP: w_next_state = S_WAIT_ACK;
            S_WAIT_ACK: begin
                w_timer_en = 1'b1;
                if (w_ack_s) w_next_state = S_WAIT_NACK;
            end
            S_WAIT_NACK: begin
                w_timer_en = 1'b1;
                if (!w_ack_s) begin
                    if (r_beat == LAST_BEAT) begin
                        w_next_state = IDLE;
                    end else begin
                        w_tx_next    = 1'b1;
                        w_next_state = S_SETUP;
                    end
                end
            end
            R_WAIT_REQ: begin
                // Waiting for the first beat is the receiver's idle, so it never times out.
                w_timer_en = (r_beat != '0);
                if (w_req_s) begin
                    w_capture    = 1'b1;
                    w_next_state = R_WAIT_NREQ;
                end
            end
            R_WAIT_NREQ: begin
                w_timer_en = 1'b1;
                if (!w_req_s) begin
                    if (r_beat == LAST_BEAT) begin
                        w_rx_done    = 1'b1;
                        w_next_state = IDLE;
                    end else begin
                        w_rx_next    = 1'b1;
                        w_next_state = R_WAIT_REQ;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
        // Peer progress on the final cycle wins over the abort.
        if (w_timer_en && (r_timer == TIMER_LAST) && (w_next_state == r_state)) begin
            w_expire     = 1'b1;
            w_next_state = IDLE;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state       <= IDLE;
            r_beat        <= '0;
            r_timer       <= '0;
            r_shift       <= '0;
            r_asm         <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_alive       <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_alive       <= 1'b1;
            r_rx_valid    <= w_rx_done;
            r_timeout_err <= w_expire;

            if (w_next_state != r_state) r_timer <= '0;
            else if (w_timer_en)         r_timer <= r_timer + 1'b1;

            if (r_state == IDLE)            r_beat <= '0;
            else if (w_tx_next || w_rx_next) r_beat <= r_beat + 1'b1;

            if (w_start)        r_shift <= tx_data;
            else if (w_tx_next) r_shift <= r_shift >> LANES;

            if (w_capture) r_asm[r_beat*LANES +: LANES] <= link_data_in;
            if (w_rx_done) r_rx_data <= r_asm;
        end
    end

    // Strobes decode straight from state so an asynchronous reset drops them at once.
    assign link_data_out = w_tx_phase ? r_shift[LANES-1:0] : '0;
    assign link_data_oe  = w_tx_phase;
    assign link_req_out  = (r_state == S_WAIT_ACK);
    assign link_ack_out  = (r_state == R_WAIT_NREQ);
    assign tx_ready      = w_tx_ready;
    assign busy          = (r_state != IDLE);
    assign rx_valid      = r_rx_valid;
    assign rx_data       = r_rx_data;
    assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_gpio_msg_link.sv
// Bench for gpio_msg_link: two cross-wired default links, a 32/8 pair and a lone TIMEOUT=15 instance.
module tb_gpio_msg_link;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Default-parameter pair A <-> B, fully cross-wired so either can send.
    logic         rstn_a, rstn_b, role_a, role_b, txv_a, txv_b;
    logic [127:0] txd_a, txd_b, rxd_a, rxd_b;
    logic         txr_a, txr_b, rxv_a, rxv_b, oe_a, oe_b, req_a, req_b, ack_a, ack_b;
    logic         busy_a, busy_b, terr_a, terr_b;
    logic [3:0]   dout_a, dout_b;

    // 32-bit / 8-lane pair VA -> VB.
    logic         rstn_v, role_va, role_vb, txv_va, txv_vb;
    logic [31:0]  txd_va, txd_vb, rxd_va, rxd_vb;
    logic         txr_va, txr_vb, rxv_va, rxv_vb, oe_va, oe_vb, req_va, req_vb, ack_va, ack_vb;
    logic         busy_va, busy_vb, terr_va, terr_vb;
    logic [7:0]   dout_va, dout_vb;

    // Lone instance with TIMEOUT=15 and bench-driven pins.
    logic         rstn_c, role_c, txv_c, c_req_in, c_ack_in;
    logic [127:0] txd_c, rxd_c;
    logic [3:0]   c_din, dout_c;
    logic         txr_c, rxv_c, oe_c, req_c, ack_c, busy_c, terr_c;

    gpio_msg_link u_a (
        .clock(clk), .resetn(rstn_a), .role(role_a), .tx_valid(txv_a), .tx_ready(txr_a),
        .tx_data(txd_a), .rx_valid(rxv_a), .rx_data(rxd_a), .link_data_out(dout_a),
        .link_data_oe(oe_a), .link_data_in(dout_b), .link_req_out(req_a), .link_req_in(req_b),
        .link_ack_out(ack_a), .link_ack_in(ack_b), .busy(busy_a), .timeout_err(terr_a)
    );

    gpio_msg_link u_b (
        .clock(clk), .resetn(rstn_b), .role(role_b), .tx_valid(txv_b), .tx_ready(txr_b),
        .tx_data(txd_b), .rx_valid(rxv_b), .rx_data(rxd_b), .link_data_out(dout_b),
        .link_data_oe(oe_b), .link_data_in(dout_a), .link_req_out(req_b), .link_req_in(req_a),
        .link_ack_out(ack_b), .link_ack_in(ack_a), .busy(busy_b), .timeout_err(terr_b)
    );

    gpio_msg_link #(.MSG_BITS(32), .LANES(8)) u_va (
        .clock(clk), .resetn(rstn_v), .role(role_va), .tx_valid(txv_va), .tx_ready(txr_va),
        .tx_data(txd_va), .rx_valid(rxv_va), .rx_data(rxd_va), .link_data_out(dout_va),
        .link_data_oe(oe_va), .link_data_in(dout_vb), .link_req_out(req_va), .link_req_in(req_vb),
        .link_ack_out(ack_va), .link_ack_in(ack_vb), .busy(busy_va), .timeout_err(terr_va)
    );

    gpio_msg_link #(.MSG_BITS(32), .LANES(8)) u_vb (
        .clock(clk), .resetn(rstn_v), .role(role_vb), .tx_valid(txv_vb), .tx_ready(txr_vb),
        .tx_data(txd_vb), .rx_valid(rxv_vb), .rx_data(rxd_vb), .link_data_out(dout_vb),
        .link_data_oe(oe_vb), .link_data_in(dout_va), .link_req_out(req_vb), .link_req_in(req_va),
        .link_ack_out(ack_vb), .link_ack_in(ack_va), .busy(busy_vb), .timeout_err(terr_vb)
    );

    gpio_msg_link #(.TIMEOUT(15)) u_c (
        .clock(clk), .resetn(rstn_c), .role(role_c), .tx_valid(txv_c), .tx_ready(txr_c),
        .tx_data(txd_c), .rx_valid(rxv_c), .rx_data(rxd_c), .link_data_out(dout_c),
        .link_data_oe(oe_c), .link_data_in(c_din), .link_req_out(req_c), .link_req_in(c_req_in),
        .link_ack_out(ack_c), .link_ack_in(c_ack_in), .busy(busy_c), .timeout_err(terr_c)
    );

    // Reference model: beat k of a message is its k-th LANES-wide slice, counted from the LSB.
    function automatic logic [3:0] model_beat4(input logic [127:0] msg, input int k);
        logic [127:0] t;
        t = msg >> (k * 4);
        return t[3:0];
    endfunction

    function automatic logic [7:0] model_beat8(input logic [31:0] msg, input int k);
        logic [31:0] t;
        t = msg >> (k * 8);
        return t[7:0];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rstn_a = 0; rstn_b = 0; rstn_v = 0; rstn_c = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            role_a = 1'($urandom); role_b = 1'($urandom); txv_a = 1'($urandom); txv_b = 1'($urandom);
            txd_a = rand128(); txd_b = rand128(); txd_c = rand128();
            role_va = 1'($urandom); role_vb = 1'($urandom); txv_va = 1'($urandom); txv_vb = 1'($urandom);
            txd_va = $urandom; txd_vb = $urandom;
            role_c = 1'($urandom); txv_c = 1'($urandom); c_din = 4'($urandom);
            c_req_in = 1'($urandom); c_ack_in = 1'($urandom);
            @(negedge clk);
            n_checks++;
            if ({txr_a, rxv_a, rxd_a, dout_a, oe_a, req_a, ack_a, busy_a, terr_a} !== '0) begin
                n_errors++; $display("FAIL reset_a cyc%0d: outputs not all zero, rx_data=%h", cyc, rxd_a);
            end
            n_checks++;
            if ({txr_b, rxv_b, rxd_b, dout_b, oe_b, req_b, ack_b, busy_b, terr_b} !== '0) begin
                n_errors++; $display("FAIL reset_b cyc%0d: outputs not all zero, rx_data=%h", cyc, rxd_b);
            end
            n_checks++;
            if ({txr_va, rxv_va, rxd_va, dout_va, oe_va, req_va, ack_va, busy_va, terr_va,
                 txr_vb, rxv_vb, rxd_vb, dout_vb, oe_vb, req_vb, ack_vb, busy_vb, terr_vb} !== '0) begin
                n_errors++; $display("FAIL reset_v cyc%0d: outputs not all zero", cyc);
            end
            n_checks++;
            if ({txr_c, rxv_c, rxd_c, dout_c, oe_c, req_c, ack_c, busy_c, terr_c} !== '0) begin
                n_errors++; $display("FAIL reset_c cyc%0d: outputs not all zero, tx_ready=%b", cyc, txr_c);
            end
        end
        txv_a = 0; txv_b = 0; txv_va = 0; txv_vb = 0; txv_c = 0;
        c_req_in = 0; c_ack_in = 0; c_din = 0; role_c = 0;
        rstn_c = 1;
        #1;
        n_checks++;
        if (txr_c !== 1'b0) begin
            n_errors++; $display("FAIL reset_release: tx_ready=%b before first clock, expected 0", txr_c);
        end
        @(negedge clk);
        n_checks++;
        if (txr_c !== 1'b1) begin
            n_errors++; $display("FAIL reset_ready: tx_ready=%b one cycle after release, expected 1", txr_c);
        end
        rstn_a = 1; rstn_b = 1; rstn_v = 1;
    endtask

    // One full message over the A/B pair; optionally flips the receiver's role mid-message.
    task automatic run_p(input bit a_sends, input logic [127:0] msg, input bit flip, input string tag);
        logic [3:0]   exp_q[$];
        logic [3:0]   got_q[$];
        int           pulses = 0;
        int           done_cyc = -1;
        bit           prev_req = 0;
        bit           rcv_req_seen = 0;
        bit           terr_seen = 0;
        logic         s_req, r_rxv, r_req;
        logic [3:0]   s_dout;
        logic [127:0] rx_got = '0;

        rstn_a = 0; rstn_b = 0; txv_a = 0; txv_b = 0;
        role_a = !a_sends; role_b = a_sends;
        repeat (2) @(negedge clk);
        rstn_a = 1; rstn_b = 1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 32; k++) exp_q.push_back(model_beat4(msg, k));

        n_checks++;
        if ((a_sends ? txr_a : txr_b) !== 1'b1) begin
            n_errors++; $display("FAIL %s ready: sender tx_ready=0, expected 1", tag);
        end
        if (a_sends) begin txv_a = 1; txd_a = msg; end
        else         begin txv_b = 1; txd_b = msg; end
        @(negedge clk);
        txv_a = 0; txv_b = 0;

        for (int cyc = 1; cyc <= 470; cyc++) begin
            s_req  = a_sends ? req_a : req_b;
            s_dout = a_sends ? dout_a : dout_b;
            r_rxv  = a_sends ? rxv_b : rxv_a;
            r_req  = a_sends ? req_b : req_a;
            if (s_req && !prev_req) got_q.push_back(s_dout);
            prev_req = s_req;
            if (r_req) rcv_req_seen = 1;
            if (terr_a || terr_b) terr_seen = 1;
            if (r_rxv) begin
                pulses++;
                rx_got = a_sends ? rxd_b : rxd_a;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (flip && got_q.size() == 10) begin
                if (a_sends) role_b = 0; else role_a = 0;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
            @(negedge clk);
        end

        n_checks++;
        if (got_q.size() !== 32) begin
            n_errors++; $display("FAIL %s beats: got %0d beats, expected 32", tag, got_q.size());
        end
        for (int k = 0; k < 32 && k < got_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== exp_q[k]) begin
                n_errors++; $display("FAIL %s beat%0d: pins %h, expected %h", tag, k, got_q[k], exp_q[k]);
            end
        end
        n_checks++;
        if (pulses !== 1) begin
            n_errors++; $display("FAIL %s rx_valid: %0d pulses, expected 1", tag, pulses);
        end
        n_checks++;
        if (rx_got !== msg) begin
            n_errors++; $display("FAIL %s rx_data: got %h, expected %h", tag, rx_got, msg);
        end
        n_checks++;
        if (done_cyc < 1 || done_cyc > 448) begin
            n_errors++; $display("FAIL %s latency: completion at cycle %0d, expected 1..448", tag, done_cyc);
        end
        n_checks++;
        if (terr_seen !== 1'b0) begin
            n_errors++; $display("FAIL %s timeout: timeout_err fired during a healthy transfer, expected none", tag);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ((a_sends ? txr_a : txr_b) !== 1'b1) begin
            n_errors++; $display("FAIL %s sender_idle: tx_ready=0 after message, expected 1", tag);
        end
        if (flip) begin
            n_checks++;
            if (rcv_req_seen !== 1'b0) begin
                n_errors++; $display("FAIL %s flip_req: receiver drove req after role flip, expected none", tag);
            end
            n_checks++;
            if ((a_sends ? txr_b : txr_a) !== 1'b1) begin
                n_errors++; $display("FAIL %s flip_ready: receiver tx_ready=0 after completion, expected 1", tag);
            end
        end
    endtask

    task automatic test_loopback_fixed();
        run_p(1'b1, 128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0, "loop_fixed");
    endtask

    task automatic test_random_loopback();
        for (int i = 0; i < 4; i++) begin
            run_p(1'($urandom_range(0, 1)), rand128(), 1'b0, $sformatf("loop_rand%0d", i));
        end
    endtask

    task automatic test_role_flip();
        run_p(1'b1, rand128(), 1'b1, "role_flip");
    endtask

    task automatic test_timeout();
        logic [127:0] msg;
        int t_req = -1;
        int t_err = -1;
        int err_cnt = 0;
        int req_cyc = 0;
        logic snap_req = 1'bx, snap_oe = 1'bx, snap_busy = 1'bx, snap_rdy = 1'bx;
        msg = rand128();
        rstn_c = 0; role_c = 0; txv_c = 0; c_ack_in = 0; c_req_in = 0;
        @(negedge clk);
        rstn_c = 1;
        repeat (2) @(negedge clk);
        txv_c = 1; txd_c = msg;
        @(negedge clk);
        txv_c = 0;
        n_checks++;
        if ({oe_c, req_c, dout_c} !== {1'b1, 1'b0, model_beat4(msg, 0)}) begin
            n_errors++; $display("FAIL to_setup: oe=%b req=%b pins=%h, expected oe=1 req=0 pins=%h",
                                 oe_c, req_c, dout_c, model_beat4(msg, 0));
        end
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (req_c) begin
                req_cyc++;
                if (t_req < 0) t_req = cyc;
            end
            if (terr_c) begin
                err_cnt++;
                if (t_err < 0) begin
                    t_err = cyc; snap_req = req_c; snap_oe = oe_c; snap_busy = busy_c; snap_rdy = txr_c;
                end
            end
        end
        n_checks++;
        if (t_req < 0 || t_err - t_req !== 15) begin
            n_errors++; $display("FAIL to_delay: timeout_err %0d cycles after req, expected 15", t_err - t_req);
        end
        n_checks++;
        if (err_cnt !== 1) begin
            n_errors++; $display("FAIL to_pulses: %0d timeout_err pulses, expected 1", err_cnt);
        end
        n_checks++;
        if (req_cyc !== 15) begin
            n_errors++; $display("FAIL to_req_len: req high %0d cycles, expected 15", req_cyc);
        end
        n_checks++;
        if ({snap_req, snap_oe, snap_busy, snap_rdy} !== 4'b0001) begin
            n_errors++; $display("FAIL to_abort: req=%b oe=%b busy=%b tx_ready=%b, expected 0 0 0 1",
                                 snap_req, snap_oe, snap_busy, snap_rdy);
        end
    endtask

    task automatic test_role_gating();
        int bad_ready = 0;
        int bad_req = 0;
        int bad_err = 0;
        int bad_busy = 0;
        rstn_c = 0; role_c = 1; txv_c = 0;
        @(negedge clk);
        rstn_c = 1;
        txv_c = 1; txd_c = rand128();
        @(negedge clk);
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (txr_c !== 1'b0) bad_ready++;
            if (req_c !== 1'b0) bad_req++;
            if (terr_c !== 1'b0) bad_err++;
            if (busy_c !== 1'b1) bad_busy++;
        end
        txv_c = 0;
        n_checks++;
        if (bad_ready !== 0) begin
            n_errors++; $display("FAIL gate_ready: tx_ready high %0d cycles as receiver, expected 0", bad_ready);
        end
        n_checks++;
        if (bad_req !== 0) begin
            n_errors++; $display("FAIL gate_req: req high %0d cycles as receiver, expected 0", bad_req);
        end
        n_checks++;
        if (bad_err !== 0) begin
            n_errors++; $display("FAIL gate_first_beat: timeout_err in %0d cycles awaiting beat 0, expected 0", bad_err);
        end
        n_checks++;
        if (bad_busy !== 0) begin
            n_errors++; $display("FAIL gate_busy: busy low %0d cycles while waiting, expected 0", bad_busy);
        end
    endtask

    task automatic test_reset_mid();
        int  rises = 0;
        bit  prev = 0;
        bit  hit = 0;
        int  terr_cnt = 0;
        int  rxv_cnt = 0;
        int  t_err = -1;
        rstn_a = 0; rstn_b = 0; role_a = 0; role_b = 1; txv_a = 0; txv_b = 0;
        repeat (2) @(negedge clk);
        rstn_a = 1; rstn_b = 1;
        repeat (3) @(negedge clk);
        txv_a = 1; txd_a = rand128();
        @(negedge clk);
        txv_a = 0;
        for (int cyc = 0; cyc < 600 && !hit; cyc++) begin
            if (req_a && !prev) begin
                rises++;
                if (rises == 11) hit = 1;
            end
            prev = req_a;
            if (!hit) @(negedge clk);
        end
        n_checks++;
        if (hit !== 1'b1) begin
            n_errors++; $display("FAIL mid_reach: only %0d beats started, expected to reach beat 10", rises);
        end
        rstn_a = 0;
        #1;
        n_checks++;
        if ({req_a, ack_a, oe_a, dout_a} !== '0) begin
            n_errors++; $display("FAIL mid_drop: req=%b ack=%b oe=%b pins=%h, expected all 0", req_a, ack_a, oe_a, dout_a);
        end
        for (int cyc = 1; cyc <= 1100; cyc++) begin
            @(negedge clk);
            if (terr_b) begin
                terr_cnt++;
                if (t_err < 0) t_err = cyc;
            end
            if (rxv_b) rxv_cnt++;
        end
        n_checks++;
        if (terr_cnt !== 1) begin
            n_errors++; $display("FAIL mid_peer_pulses: %0d peer timeout_err pulses, expected 1", terr_cnt);
        end
        n_checks++;
        if (t_err < 1000 || t_err > 1030) begin
            n_errors++; $display("FAIL mid_peer_delay: peer timeout at cycle %0d, expected 1000..1030", t_err);
        end
        n_checks++;
        if (rxv_cnt !== 0) begin
            n_errors++; $display("FAIL mid_rx_valid: %0d rx_valid pulses, expected 0", rxv_cnt);
        end
        n_checks++;
        if (rxd_b !== 128'h0) begin
            n_errors++; $display("FAIL mid_rx_data: rx_data=%h after abort, expected 0", rxd_b);
        end
        rstn_a = 1;
    endtask

    task automatic run_v(input logic [31:0] msg, input string tag);
        logic [7:0]  got_q[$];
        int          pulses = 0;
        int          done_cyc = -1;
        bit          prev_req = 0;
        logic [31:0] rx_got = '0;
        rstn_v = 0; txv_va = 0; txv_vb = 0; role_va = 0; role_vb = 1;
        repeat (2) @(negedge clk);
        rstn_v = 1;
        repeat (3) @(negedge clk);
        txv_va = 1; txd_va = msg;
        @(negedge clk);
        txv_va = 0;
        for (int cyc = 1; cyc <= 120; cyc++) begin
            if (req_va && !prev_req) got_q.push_back(dout_va);
            prev_req = req_va;
            if (rxv_vb) begin
                pulses++; rx_got = rxd_vb;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
            @(negedge clk);
        end
        n_checks++;
        if (got_q.size() !== 4) begin
            n_errors++; $display("FAIL %s beats: got %0d beats, expected 4", tag, got_q.size());
        end
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== model_beat8(msg, k)) begin
                n_errors++; $display("FAIL %s beat%0d: pins %h, expected %h", tag, k, got_q[k], model_beat8(msg, k));
            end
        end
        n_checks++;
        if (pulses !== 1 || rx_got !== msg) begin
            n_errors++; $display("FAIL %s rx: %0d pulses data %h, expected 1 pulse data %h", tag, pulses, rx_got, msg);
        end
        n_checks++;
        if (done_cyc < 1 || done_cyc > 56) begin
            n_errors++; $display("FAIL %s latency: completion at cycle %0d, expected 1..56", tag, done_cyc);
        end
    endtask

    task automatic test_variant();
        run_v(32'hCAFEBABE, "var_cafe");
        run_v($urandom, "var_rand");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "time limit");
    end

    initial begin
        rstn_a = 0; rstn_b = 0; rstn_v = 0; rstn_c = 0;
        role_a = 0; role_b = 0; role_va = 0; role_vb = 0; role_c = 0;
        txv_a = 0; txv_b = 0; txv_va = 0; txv_vb = 0; txv_c = 0;
        txd_a = '0; txd_b = '0; txd_va = '0; txd_vb = '0; txd_c = '0;
        c_din = '0; c_req_in = 0; c_ack_in = 0;
        test_reset();
        test_loopback_fixed();
        test_timeout();
        test_role_gating();
        test_role_flip();
        test_random_loopback();
        test_reset_mid();
        test_variant();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
